// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - iterative shift-add unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH
// Retires one multiplier bit per clock and stops early once the remaining multiplier bits are zero.
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplr_q, mplr_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d = {{WIDTH{1'b0}}, multiplicand};
          mplr_d  = multiplier;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (mplr_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        // A zero multiplier still spends exactly one cycle here.
        if (mplr_d == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Handshake flags are registered copies of the next state, so no input reaches them combinationally.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplr_q      <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplr_q      <= mplr_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign product   = acc_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - self-checking bench for seq_multiplier
// Directed vector table, backpressure and reset corner cases, then randomized ops against an arithmetic model.
module tb_seq_multiplier;

  localparam int W = 32;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;

  int checks = 0;
  int errors = 0;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
    int             n;
  } vec_t;

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_product(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] wa, wb;
    wa = {{W{1'b0}}, a};
    wb = {{W{1'b0}}, b};
    return wa * wb;
  endfunction

  function automatic int ref_runs(input logic [W-1:0] b);
    int n;
    n = 1;
    for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
    return n;
  endfunction

  // Entered and left on a negedge. With bp set, new operands are offered during the
  // out_ready-low window and left on the bus, so the next call picks them up with gap 0.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int gap, input int rgap, input bit bp,
                        input logic [W-1:0] na, input logic [W-1:0] nb);
    logic [2*W-1:0] ep;
    int en, lat, busy_cnt;
    bit held, blocked;
    ep = ref_product(a, b);
    en = ref_runs(b);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    multiplicand = a;
    multiplier = b;
    chk({name, " in_ready"}, {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    multiplicand = $urandom;
    multiplier = $urandom;
    lat = 1;
    busy_cnt = 0;
    while (!out_valid && lat <= W + 4) begin
      busy_cnt += int'(busy);
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: out_valid=0 after %0d edges, required within %0d", name, lat, en + 1);
      return;
    end
    chk({name, " product"}, product, ep);
    chk({name, " busy_cycles"}, 64'(busy_cnt), 64'(en));
    chk({name, " latency"}, 64'(lat), 64'(en + 1));
    held = 1'b1;
    blocked = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < rgap; i++) begin
      if (bp) begin
        in_valid = 1'b1;
        multiplicand = na;
        multiplier = nb;
      end
      @(negedge clk);
      if (!out_valid || product !== ep) held = 1'b0;
      if (in_ready) blocked = 1'b0;
    end
    if (rgap > 0) chk({name, " hold"}, {63'd0, held}, 64'd1);
    if (bp) chk({name, " no_accept_in_done"}, {63'd0, blocked}, 64'd1);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, " out_valid_fall"}, {63'd0, out_valid}, 64'd0);
    chk({name, " idle_ready"}, {63'd0, in_ready}, 64'd1);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{a: 32'd156,        b: 32'd23,         p: 64'd3588,               n: 5};
    vecs[1] = '{a: 32'd0,          b: 32'd1,          p: 64'd0,                  n: 1};
    vecs[2] = '{a: 32'd156,        b: 32'd0,          p: 64'd0,                  n: 1};
    vecs[3] = '{a: 32'd1,          b: 32'd10421,      p: 64'd10421,              n: 14};
    vecs[4] = '{a: 32'hFFFFFFFF,   b: 32'hFFFFFFFF,   p: 64'hFFFFFFFE00000001,   n: 32};
    vecs[5] = '{a: 32'h80000000,   b: 32'h80000000,   p: 64'h4000000000000000,   n: 32};
    vecs[6] = '{a: 32'd231352,     b: 32'd4,          p: 64'd925408,             n: 3};

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    repeat (3) @(negedge clk);
    chk("reset product", product, 64'd0);
    chk("reset in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset busy", {63'd0, busy}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // The table's products and run counts are hand-derived; make sure the model agrees with them.
    foreach (vecs[i]) begin
      chk($sformatf("model p%0d", i), ref_product(vecs[i].a, vecs[i].b), vecs[i].p);
      chk($sformatf("model n%0d", i), 64'(ref_runs(vecs[i].b)), 64'(vecs[i].n));
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, 1, 2, 1'b0, '0, '0);
    end

    run_op("bp_first", 32'd156, 32'd23, 1, 10, 1'b1, 32'd1000, 32'd77);
    run_op("bp_second", 32'd1000, 32'd77, 0, 0, 1'b0, '0, '0);

    in_valid = 1'b1;
    multiplicand = 32'd231352;
    multiplier = 32'd4;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst_mid busy_before", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid product", product, 64'd0);
    chk("rst_mid busy", {63'd0, busy}, 64'd0);
    chk("rst_mid in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_mid out_valid", {63'd0, out_valid}, 64'd0);
    begin
      bit quiet;
      quiet = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) begin
        @(negedge clk);
        if (out_valid || busy) quiet = 1'b0;
      end
      chk("rst_mid no_pulse", {63'd0, quiet}, 64'd1);
    end
    run_op("after_reset", 32'd231352, 32'd4, 0, 1, 1'b0, '0, '0);

    for (int k = 0; k < 1500; k++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0) rb = '0;
      if ($urandom_range(0, 15) == 0) ra = '0;
      run_op($sformatf("rand%0d", k), ra, rb, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, '0, '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
